// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID register for the 5-stage MIPS pipeline.
// Talks to a variable-latency req/ack instruction memory and buffers one response across decode stalls.
module fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_pc,
    input  logic              stall_decode,
    input  logic              pcsrc_decode,
    input  logic [ADDR_W-1:0] branch_target_decode,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr_decode,
    output logic [ADDR_W-1:0] pcplus4_decode,
    output logic              valid_decode,
    output logic [ADDR_W-1:0] pc_fetch
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] pcplus4_q, pcplus4_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] buf_instr_q, buf_instr_d;
    logic [ADDR_W-1:0] buf_pcplus4_q, buf_pcplus4_d;

    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_plus4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            instr_q       <= '0;
            pcplus4_q     <= '0;
            valid_q       <= 1'b0;
            buf_instr_q   <= '0;
            buf_pcplus4_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            instr_q       <= instr_d;
            pcplus4_q     <= pcplus4_d;
            valid_q       <= valid_d;
            buf_instr_q   <= buf_instr_d;
            buf_pcplus4_q <= buf_pcplus4_d;
        end
    end

    always_comb begin
        stall         = stall_pc | stall_decode;
        redirect      = pcsrc_decode & ~stall;
        target        = branch_target_decode & ~ADDR_W'(3);
        pc_plus4      = pc_q + ADDR_W'(4);

        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        buf_instr_d   = buf_instr_q;
        buf_pcplus4_d = buf_pcplus4_q;
        instr_d       = instr_q;
        pcplus4_d     = pcplus4_q;
        valid_d       = valid_q;

        // Unstalled IF/ID defaults to a bubble; this also performs the redirect flush.
        if (!stall) begin
            instr_d   = '0;
            pcplus4_d = '0;
            valid_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (redirect) begin
                    pc_d       = target;
                    req_addr_d = target;
                end
            end
            FETCH: begin
                if (redirect) begin
                    pc_d = target;
                    // req_addr must stay put until the outstanding request is acked.
                    if (imem_ack) req_addr_d = target;
                    else          state_d    = DRAIN;
                end else if (imem_ack) begin
                    if (stall) begin
                        buf_instr_d   = imem_rdata;
                        buf_pcplus4_d = pc_plus4;
                        state_d       = HOLD;
                    end else begin
                        instr_d    = imem_rdata;
                        pcplus4_d  = pc_plus4;
                        valid_d    = 1'b1;
                        pc_d       = pc_plus4;
                        req_addr_d = pc_plus4;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d          = target;
                    req_addr_d    = target;
                    buf_instr_d   = '0;
                    buf_pcplus4_d = '0;
                    state_d       = FETCH;
                end else if (!stall) begin
                    instr_d       = buf_instr_q;
                    pcplus4_d     = buf_pcplus4_q;
                    valid_d       = 1'b1;
                    pc_d          = buf_pcplus4_q;
                    req_addr_d    = buf_pcplus4_q;
                    buf_instr_d   = '0;
                    buf_pcplus4_d = '0;
                    state_d       = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) pc_d = target;
                if (imem_ack) begin
                    req_addr_d = redirect ? target : pc_q;
                    state_d    = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign imem_req       = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr      = req_addr_q;
    assign instr_decode   = instr_q;
    assign pcplus4_decode = pcplus4_q;
    assign valid_decode   = valid_q;
    assign pc_fetch       = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: each task drives the memory/hazard inputs and compares an output snapshot.
// Snapshot layout: {imem_req, imem_addr, valid_decode, instr_decode, pcplus4_decode, pc_fetch}.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_pc = 1'b0;
    logic        stall_decode = 1'b0;
    logic        pcsrc_decode = 1'b0;
    logic [31:0] branch_target_decode = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr_decode;
    logic [31:0] pcplus4_decode;
    logic        valid_decode;
    logic [31:0] pc_fetch;

    int tests = 0;
    int fails = 0;

    logic [129:0] snap;
    logic [129:0] exp_v;
    assign snap = {imem_req, imem_addr, valid_decode, instr_decode, pcplus4_decode, pc_fetch};

    fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .stall_pc(stall_pc), .stall_decode(stall_decode),
        .pcsrc_decode(pcsrc_decode), .branch_target_decode(branch_target_decode),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_decode(instr_decode), .pcplus4_decode(pcplus4_decode),
        .valid_decode(valid_decode), .pc_fetch(pc_fetch)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        exp_v = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        if (snap !== exp_v) begin $display("FAIL reset_state got %h want %h", snap, exp_v); fails++; end
        tests++;
        rst = 1'b0;
        @(negedge clk);
        exp_v = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        if (snap !== exp_v) begin $display("FAIL reset_first_req got %h want %h", snap, exp_v); fails++; end
        tests++;
    endtask

    task automatic test_zero_wait();
        imem_ack = 1'b1; imem_rdata = 32'h2001_0005;
        @(negedge clk);
        exp_v = {1'b1, 32'h4, 1'b1, 32'h2001_0005, 32'h4, 32'h4};
        if (snap !== exp_v) begin $display("FAIL zw_first got %h want %h", snap, exp_v); fails++; end
        tests++;
        imem_rdata = 32'h2002_000A;
        @(negedge clk);
        exp_v = {1'b1, 32'h8, 1'b1, 32'h2002_000A, 32'h8, 32'h8};
        if (snap !== exp_v) begin $display("FAIL zw_second got %h want %h", snap, exp_v); fails++; end
        tests++;
        imem_ack = 1'b0;
        @(negedge clk);
        exp_v = {1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 32'h8};
        if (snap !== exp_v) begin $display("FAIL zw_bubble got %h want %h", snap, exp_v); fails++; end
        tests++;
    endtask

    task automatic test_latency();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            exp_v = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
            if (snap !== exp_v) begin $display("FAIL lat_wait%0d got %h want %h", i, snap, exp_v); fails++; end
            tests++;
            if (i == 2) begin imem_ack = 1'b1; imem_rdata = 32'h8C88_0004; end
            @(negedge clk);
        end
        imem_ack = 1'b0;
        exp_v = {1'b1, 32'h4, 1'b1, 32'h8C88_0004, 32'h4, 32'h4};
        if (snap !== exp_v) begin $display("FAIL lat_deliver got %h want %h", snap, exp_v); fails++; end
        tests++;
        @(negedge clk);
        exp_v = {1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 32'h4};
        if (snap !== exp_v) begin $display("FAIL lat_once got %h want %h", snap, exp_v); fails++; end
        tests++;
        imem_ack = 1'b1; imem_rdata = 32'h0085_1020;
        @(negedge clk);
        imem_ack = 1'b0;
        exp_v = {1'b1, 32'h8, 1'b1, 32'h0085_1020, 32'h8, 32'h8};
        if (snap !== exp_v) begin $display("FAIL lat_next got %h want %h", snap, exp_v); fails++; end
        tests++;
    endtask

    task automatic test_stall_hold();
        imem_ack = 1'b1; imem_rdata = 32'hAC02_0008;
        stall_pc = 1'b1; stall_decode = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        exp_v = {1'b0, 32'h8, 1'b1, 32'h0085_1020, 32'h8, 32'h8};
        if (snap !== exp_v) begin $display("FAIL hold_c1 got %h want %h", snap, exp_v); fails++; end
        tests++;
        @(negedge clk);
        if (snap !== exp_v) begin $display("FAIL hold_c2 got %h want %h", snap, exp_v); fails++; end
        tests++;
        stall_pc = 1'b0; stall_decode = 1'b0;
        @(negedge clk);
        exp_v = {1'b1, 32'hC, 1'b1, 32'hAC02_0008, 32'hC, 32'hC};
        if (snap !== exp_v) begin $display("FAIL hold_release got %h want %h", snap, exp_v); fails++; end
        tests++;
    endtask

    task automatic test_redirect_drain();
        imem_ack = 1'b1; imem_rdata = 32'h1000_0003;
        @(negedge clk);
        imem_ack = 1'b0;
        exp_v = {1'b1, 32'h10, 1'b1, 32'h1000_0003, 32'h10, 32'h10};
        if (snap !== exp_v) begin $display("FAIL drain_setup got %h want %h", snap, exp_v); fails++; end
        tests++;
        pcsrc_decode = 1'b1; branch_target_decode = 32'h40;
        @(negedge clk);
        pcsrc_decode = 1'b0;
        exp_v = {1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 32'h40};
        if (snap !== exp_v) begin $display("FAIL drain_flush got %h want %h", snap, exp_v); fails++; end
        tests++;
        @(negedge clk);
        if (snap !== exp_v) begin $display("FAIL drain_addr_stable got %h want %h", snap, exp_v); fails++; end
        tests++;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        exp_v = {1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 32'h40};
        if (snap !== exp_v) begin $display("FAIL drain_drop got %h want %h", snap, exp_v); fails++; end
        tests++;
    endtask

    task automatic test_stalled_pcsrc();
        pcsrc_decode = 1'b1; branch_target_decode = 32'h100; stall_pc = 1'b1;
        @(negedge clk);
        pcsrc_decode = 1'b0; stall_pc = 1'b0;
        exp_v = {1'b1, 32'h40, 1'b0, 32'h0, 32'h0, 32'h40};
        if (snap !== exp_v) begin $display("FAIL stalled_pcsrc got %h want %h", snap, exp_v); fails++; end
        tests++;
        imem_ack = 1'b1; imem_rdata = 32'h0123_4567;
        @(negedge clk);
        imem_ack = 1'b0;
        exp_v = {1'b1, 32'h44, 1'b1, 32'h0123_4567, 32'h44, 32'h44};
        if (snap !== exp_v) begin $display("FAIL stalled_pcsrc_fetch got %h want %h", snap, exp_v); fails++; end
        tests++;
    endtask

    task automatic test_redirect_ack();
        imem_ack = 1'b1; imem_rdata = 32'hBADB_AD00;
        pcsrc_decode = 1'b1; branch_target_decode = 32'h80;
        @(negedge clk);
        imem_ack = 1'b0; pcsrc_decode = 1'b0;
        exp_v = {1'b1, 32'h80, 1'b0, 32'h0, 32'h0, 32'h80};
        if (snap !== exp_v) begin $display("FAIL redirect_ack got %h want %h", snap, exp_v); fails++; end
        tests++;
    endtask

    task automatic test_hold_redirect();
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111; stall_decode = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        exp_v = {1'b0, 32'h80, 1'b0, 32'h0, 32'h0, 32'h80};
        if (snap !== exp_v) begin $display("FAIL hold_redir_enter got %h want %h", snap, exp_v); fails++; end
        tests++;
        stall_decode = 1'b0; pcsrc_decode = 1'b1; branch_target_decode = 32'h103;
        @(negedge clk);
        pcsrc_decode = 1'b0;
        exp_v = {1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 32'h100};
        if (snap !== exp_v) begin $display("FAIL hold_redir_target got %h want %h", snap, exp_v); fails++; end
        tests++;
        imem_ack = 1'b1; imem_rdata = 32'h2222_2222;
        @(negedge clk);
        imem_ack = 1'b0;
        exp_v = {1'b1, 32'h104, 1'b1, 32'h2222_2222, 32'h104, 32'h104};
        if (snap !== exp_v) begin $display("FAIL hold_redir_fetch got %h want %h", snap, exp_v); fails++; end
        tests++;
    endtask

    task automatic test_wrap();
        imem_ack = 1'b1; imem_rdata = 32'h0;
        pcsrc_decode = 1'b1; branch_target_decode = 32'hFFFF_FFFC;
        @(negedge clk);
        pcsrc_decode = 1'b0; imem_rdata = 32'h3333_3333;
        exp_v = {1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC};
        if (snap !== exp_v) begin $display("FAIL wrap_target got %h want %h", snap, exp_v); fails++; end
        tests++;
        @(negedge clk);
        imem_ack = 1'b0;
        exp_v = {1'b1, 32'h0, 1'b1, 32'h3333_3333, 32'h0, 32'h0};
        if (snap !== exp_v) begin $display("FAIL wrap_pc got %h want %h", snap, exp_v); fails++; end
        tests++;
    endtask

    task automatic test_async_reset();
        imem_ack = 1'b1; imem_rdata = 32'h4444_4444;
        @(negedge clk);
        imem_ack = 1'b0;
        #2 rst = 1'b1;
        #1;
        exp_v = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        if (snap !== exp_v) begin $display("FAIL rst_midreq got %h want %h", snap, exp_v); fails++; end
        tests++;
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = 32'h9999_9999;
        rst = 1'b0;
        @(negedge clk);
        imem_ack = 1'b0;
        exp_v = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        if (snap !== exp_v) begin $display("FAIL rst_late_ack got %h want %h", snap, exp_v); fails++; end
        tests++;
        imem_ack = 1'b1; imem_rdata = 32'h5555_5555;
        @(negedge clk);
        imem_rdata = 32'h6666_6666; stall_decode = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        exp_v = {1'b0, 32'h4, 1'b1, 32'h5555_5555, 32'h4, 32'h4};
        if (snap !== exp_v) begin $display("FAIL rst_hold_enter got %h want %h", snap, exp_v); fails++; end
        tests++;
        #2 rst = 1'b1;
        #1;
        exp_v = {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        if (snap !== exp_v) begin $display("FAIL rst_in_hold got %h want %h", snap, exp_v); fails++; end
        tests++;
        @(negedge clk);
        stall_decode = 1'b0; rst = 1'b0;
        @(negedge clk);
        exp_v = {1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0};
        if (snap !== exp_v) begin $display("FAIL rst_restart got %h want %h", snap, exp_v); fails++; end
        tests++;
        imem_ack = 1'b1; imem_rdata = 32'h7777_7777;
        @(negedge clk);
        imem_ack = 1'b0;
        exp_v = {1'b1, 32'h4, 1'b1, 32'h7777_7777, 32'h4, 32'h4};
        if (snap !== exp_v) begin $display("FAIL rst_refetch got %h want %h", snap, exp_v); fails++; end
        tests++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_stall_hold();
        test_redirect_drain();
        test_stalled_pcsrc();
        test_redirect_ack();
        test_hold_redirect();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS pipeline; directly upstream of decode.
- Consumes the hazard unit's stall_pc/stall_decode and decode's branch redirect.
- Drives a req/ack instruction-memory port with variable latency. Holds one instruction in a hold buffer while decode is stalled, and discards wrong-path responses after a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC and memory address width.
- DATA_W, 32, instruction width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- stall_pc  input  1  hazard unit: hold PC.
- stall_decode  input  1  hazard unit: hold IF/ID.
- pcsrc_decode  input  1  branch taken, resolved in decode.
- branch_target_decode  input  ADDR_W  redirect target.
- imem_req  output  1  fetch request valid.
- imem_addr  output  ADDR_W  fetch address, word aligned.
- imem_ack  input  1  response valid; at most one per request.
- imem_rdata  input  DATA_W  instruction, valid with imem_ack.
- instr_decode  output  DATA_W  IF/ID instruction.
- pcplus4_decode  output  ADDR_W  IF/ID PC+4.
- valid_decode  output  1  IF/ID holds a real instruction.
- pc_fetch  output  ADDR_W  current architectural fetch PC.

Behaviour:
- Reset values: pc=RESET_PC, req_addr=RESET_PC, state=IDLE, imem_req=0, instr_decode=0, pcplus4_decode=0, valid_decode=0, hold buffer empty. Reset asserted mid-request abandons it; a late ack after reset is ignored.
- stall = stall_pc | stall_decode; both PC and IF/ID use it.
- redirect = pcsrc_decode & ~stall. pcsrc_decode is ignored while stall=1.
- States:
  - IDLE: imem_req=0. Go to FETCH next cycle.
  - FETCH: imem_req=1, imem_addr=req_addr (registered copy of pc).
  - HOLD: imem_req=0. Instruction buffered because of stall.
  - DRAIN: imem_req=1 on the stale address. Response will be discarded.
- Handshake: once imem_req rises, imem_addr stays stable and imem_req stays high until the ack cycle inclusive. A redirect never changes imem_addr mid-request.
- FETCH, ack=1, stall=0, no redirect:
  - IF/ID <= {imem_rdata, pc+4, valid=1}.
  - pc and req_addr <= pc+4; remain in FETCH.
  - Zero-wait memory therefore sustains 1 instr/cycle; IF/ID is valid the cycle after the ack.
- FETCH, ack=1, stall=1: buffer {imem_rdata, pc+4}; IF/ID and pc hold; go to HOLD.
- FETCH, ack=0, stall=0, no redirect: IF/ID <= bubble (instr 0, pcplus4 0, valid 0).
- stall=1 in any state: IF/ID and pc hold.
- HOLD, stall=0:
  - IF/ID <= buffer with valid=1; pc and req_addr <= buffered pc+4.
  - Buffer cleared; go to FETCH.
- redirect in FETCH, ack=0: pc <= target; IF/ID flushed to bubble; go to DRAIN.
- redirect in FETCH, ack=1 (same cycle): response discarded; pc and req_addr <= target; IF/ID flushed; stay in FETCH.
- redirect in HOLD: buffer discarded; pc and req_addr <= target; IF/ID flushed; go to FETCH.
- DRAIN, ack=1: discard response; req_addr <= pc; go to FETCH.
- Redirect in DRAIN: pc <= new target (latest wins); IF/ID flushed.
- A DRAIN ack never writes IF/ID.
- PC arithmetic: pc+4 is modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
- Target bits [1:0] are forced to 0.
- pc_fetch = pc.

Test Plan:
- Reset, then zero-wait memory returning 0x2001_0005, 0x2002_000A:
  - imem_req rises 1 cycle after rst deasserts; addr 0x0 then 0x4.
  - IF/ID shows {0x2001_0005, 0x4, 1} then {0x2002_000A, 0x8, 1}.
- Memory with 3-cycle ack latency:
  - imem_addr stays 0x0 for 3 cycles while valid_decode=0.
  - Instruction appears once; pc then 0x4.
- stall_decode=stall_pc=1 on the ack cycle of addr 0x8, held 2 cycles:
  - imem_req=0 in HOLD; IF/ID unchanged.
  - After release IF/ID = {rdata@0x8, 0xC, 1}; next fetch addr 0xC.
- pcsrc_decode=1, target 0x40, while a request to 0x10 is outstanding (ack 2 cycles later):
  - IF/ID bubble; addr stays 0x10 until ack; that response is dropped.
  - Next request addr 0x40.
- pcsrc_decode=1 with stall=1: no redirect, pc unchanged. Separately, redirect to 0x80 coincident with ack: rdata discarded, next addr 0x80.
- Assert rst mid-request and during HOLD: all outputs return to reset values immediately (async). The fetch restarts at RESET_PC.
